// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: register index width, forwarding-select
// encodings and the hazard controller state type.
package cpu_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// slave: the controller; master: whoever drives the pipeline fields.
interface hazard_ctrl_unit_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [REG_IDX_W-1:0] ID_rs;
    logic [REG_IDX_W-1:0] ID_rt;
    logic                 ID_UsesRs;
    logic                 ID_UsesRt;
    logic                 ID_Jump;
    logic [REG_IDX_W-1:0] EX_rs;
    logic [REG_IDX_W-1:0] EX_rt;
    logic [REG_IDX_W-1:0] EX_dst;
    logic                 EX_MemRead;
    logic                 EX_RegWrite;
    logic                 EX_BranchTaken;
    logic                 EX_MulDivStart;
    logic                 MEM_RegWrite;
    logic [REG_IDX_W-1:0] MEM_dst;
    logic                 WB_RegWrite;
    logic [REG_IDX_W-1:0] WB_dst;

    logic                 pc_stall;
    logic                 if_id_stall;
    logic                 if_id_flush;
    logic                 id_ex_stall;
    logic                 id_ex_flush;
    logic                 ex_mem_flush;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;
    logic                 md_busy;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport slave (
        input  ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_Jump,
        input  EX_rs, EX_rt, EX_dst, EX_MemRead, EX_RegWrite,
        input  EX_BranchTaken, EX_MulDivStart,
        input  MEM_RegWrite, MEM_dst, WB_RegWrite, WB_dst,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        output ex_mem_flush, fwd_a, fwd_b, md_busy, stall_cnt, flush_cnt
    );

    modport master (
        output ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_Jump,
        output EX_rs, EX_rt, EX_dst, EX_MemRead, EX_RegWrite,
        output EX_BranchTaken, EX_MulDivStart,
        output MEM_RegWrite, MEM_dst, WB_RegWrite, WB_dst,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        input  ex_mem_flush, fwd_a, fwd_b, md_busy, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Forwarding select for one EX source operand. The younger MEM result
// wins over WB; register 0 is never forwarded.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src_i,
    input  logic                 mem_we_i,
    input  logic [REG_IDX_W-1:0] mem_dst_i,
    input  logic                 wb_we_i,
    input  logic [REG_IDX_W-1:0] wb_dst_i,
    output logic [1:0]           sel_o
);

    // Pick the newest in-flight producer of src_i.
    always_comb begin
        sel_o = FWD_RF;
        if (mem_we_i && (mem_dst_i != '0) && (mem_dst_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_we_i && (wb_dst_i != '0) && (wb_dst_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller sitting after the ID/EX register: stalls and flushes
// the front of the pipeline, holds mul/div in EX for MD_LATENCY cycles,
// selects EX operand forwarding and counts stall cycles / branch flushes.
module hazard_ctrl_unit
    import cpu_pkg::*;
#(
    parameter int MD_LATENCY = 32,  // must be >= 2
    parameter int CNT_W      = 32
)(
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_unit_if.slave hz
);

    localparam int MD_CNT_W = $clog2(MD_LATENCY + 1);

    hz_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic       load_use;
    logic       branch_flush;
    logic       pc_stall, if_id_stall, if_id_flush;
    logic       id_ex_stall, id_ex_flush, ex_mem_flush, md_busy;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // A load in EX whose destination is read by the instruction in ID.
    assign load_use = hz.EX_MemRead && hz.EX_RegWrite && (hz.EX_dst != '0) &&
                      ((hz.ID_UsesRs && (hz.ID_rs == hz.EX_dst)) ||
                       (hz.ID_UsesRt && (hz.ID_rt == hz.EX_dst)));

    // Stall/flush decode and next state; reset forces a full bubble.
    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        branch_flush = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.EX_BranchTaken) begin
                        // Wrong-path instructions in IF/ID and ID/EX die.
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        branch_flush = 1'b1;
                    end else if (hz.EX_MulDivStart) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_flush = 1'b1;
                        md_busy      = 1'b1;
                        md_cnt_d     = MD_CNT_W'(MD_LATENCY - 1);
                        state_d      = MD_WAIT;
                    end else if (load_use) begin
                        // Jump in ID is held, not flushed; it retries next cycle.
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end else if (hz.ID_Jump) begin
                        if_id_flush  = 1'b1;
                    end
                end
                MD_WAIT: begin
                    md_busy  = 1'b1;
                    md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                    if (md_cnt_q > MD_CNT_W'(1)) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else begin
                        // Last EX cycle: let the mul/div move on to MEM.
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(branch_flush);
    end

    // State, mul/div residency counter and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    fwd_sel u_fwd_a (
        .src_i     (hz.EX_rs),
        .mem_we_i  (hz.MEM_RegWrite),
        .mem_dst_i (hz.MEM_dst),
        .wb_we_i   (hz.WB_RegWrite),
        .wb_dst_i  (hz.WB_dst),
        .sel_o     (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .src_i     (hz.EX_rt),
        .mem_we_i  (hz.MEM_RegWrite),
        .mem_dst_i (hz.MEM_dst),
        .wb_we_i   (hz.WB_RegWrite),
        .wb_dst_i  (hz.WB_dst),
        .sel_o     (fwd_b_raw)
    );

    assign hz.pc_stall     = pc_stall;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_stall  = id_ex_stall;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.md_busy      = md_busy;
    assign hz.fwd_a        = rst ? FWD_RF : fwd_a_raw;
    assign hz.fwd_b        = rst ? FWD_RF : fwd_b_raw;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios with literal expectations,
// then randomized traffic; a negedge process compares every output against
// a behavioural model each cycle.
module tb_hazard_ctrl_unit;
    import cpu_pkg::*;

    localparam int L  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.CNT_W(CW)) hz();

    hazard_ctrl_unit #(.MD_LATENCY(L), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_in_md = 1'b0;   // a mul/div currently occupies EX
    int m_age   = 0;      // which EX cycle of the mul/div (1..L)
    int m_stall = 0;
    int m_flush = 0;

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (hz.MEM_RegWrite && hz.MEM_dst != 0 && hz.MEM_dst == src) return 2'b01;
        if (hz.WB_RegWrite && hz.WB_dst != 0 && hz.WB_dst == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit lu_model();
        if (!(hz.EX_MemRead && hz.EX_RegWrite) || hz.EX_dst == 0) return 1'b0;
        return (hz.ID_UsesRs && hz.ID_rs == hz.EX_dst) ||
               (hz.ID_UsesRt && hz.ID_rt == hz.EX_dst);
    endfunction

    always @(negedge clk) begin
        bit e_pc, e_ifs, e_iff, e_ids, e_idf, e_exf, e_busy, e_br;
        logic [1:0] e_fa, e_fb;
        e_pc = 0; e_ifs = 0; e_iff = 0; e_ids = 0; e_idf = 0; e_exf = 0;
        e_busy = 0; e_br = 0;
        e_fa = rst ? 2'b00 : fwd_model(hz.EX_rs);
        e_fb = rst ? 2'b00 : fwd_model(hz.EX_rt);
        if (rst) begin
            e_iff = 1; e_idf = 1; e_exf = 1;
        end else if (!m_in_md) begin
            if (hz.EX_BranchTaken) begin
                e_iff = 1; e_idf = 1; e_br = 1;
            end else if (hz.EX_MulDivStart) begin
                e_pc = 1; e_ifs = 1; e_ids = 1; e_exf = 1; e_busy = 1;
            end else if (lu_model()) begin
                e_pc = 1; e_ifs = 1; e_idf = 1;
            end else if (hz.ID_Jump) begin
                e_iff = 1;
            end
        end else begin
            e_busy = 1;
            if (m_age < L) begin
                e_pc = 1; e_ifs = 1; e_ids = 1; e_exf = 1;
            end
        end
        chk("pc_stall",     hz.pc_stall,     e_pc);
        chk("if_id_stall",  hz.if_id_stall,  e_ifs);
        chk("if_id_flush",  hz.if_id_flush,  e_iff);
        chk("id_ex_stall",  hz.id_ex_stall,  e_ids);
        chk("id_ex_flush",  hz.id_ex_flush,  e_idf);
        chk("ex_mem_flush", hz.ex_mem_flush, e_exf);
        chk("md_busy",      hz.md_busy,      e_busy);
        chk("fwd_a",        hz.fwd_a,        e_fa);
        chk("fwd_b",        hz.fwd_b,        e_fb);
        chk("stall_cnt",    hz.stall_cnt,    m_stall);
        chk("flush_cnt",    hz.flush_cnt,    m_flush);
        // advance model to what the next clock edge produces
        if (rst) begin
            m_in_md = 0; m_age = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_stall = (m_stall + int'(e_pc)) % (1 << CW);
            m_flush = (m_flush + int'(e_br)) % (1 << CW);
            if (!m_in_md) begin
                if (!hz.EX_BranchTaken && hz.EX_MulDivStart) begin
                    m_in_md = 1; m_age = 2;
                end
            end else if (m_age >= L) begin
                m_in_md = 0; m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        hz.ID_rs = 0; hz.ID_rt = 0; hz.ID_UsesRs = 0; hz.ID_UsesRt = 0; hz.ID_Jump = 0;
        hz.EX_rs = 0; hz.EX_rt = 0; hz.EX_dst = 0; hz.EX_MemRead = 0; hz.EX_RegWrite = 0;
        hz.EX_BranchTaken = 0; hz.EX_MulDivStart = 0;
        hz.MEM_RegWrite = 0; hz.MEM_dst = 0; hz.WB_RegWrite = 0; hz.WB_dst = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        hz.EX_MemRead = 1; hz.EX_RegWrite = 1; hz.EX_dst = 8;
        hz.ID_rs = 8; hz.ID_UsesRs = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        // reset: flushes high, forwarding suppressed, start ignored
        hz.MEM_RegWrite = 1; hz.MEM_dst = 5; hz.EX_rs = 5; hz.EX_MulDivStart = 1;
        #2;
        chk("rst_fwd_a", hz.fwd_a, 0);
        chk("rst_if_id_flush", hz.if_id_flush, 1);
        chk("rst_ex_mem_flush", hz.ex_mem_flush, 1);
        chk("rst_md_busy", hz.md_busy, 0);
        tick();
        rst = 0; idle(); set_lu();
        #2;
        chk("lu_pc_stall", hz.pc_stall, 1);
        chk("lu_if_id_stall", hz.if_id_stall, 1);
        chk("lu_id_ex_flush", hz.id_ex_flush, 1);
        chk("lu_id_ex_stall", hz.id_ex_stall, 0);
        tick();
        idle();
        #2;
        chk("lu_after_pc", hz.pc_stall, 0);
        chk("lu_stall_cnt", hz.stall_cnt, 1);
        tick();
        set_lu(); hz.ID_Jump = 1;
        #2;
        chk("lujmp_if_id_flush", hz.if_id_flush, 0);
        chk("lujmp_pc_stall", hz.pc_stall, 1);
        tick();
        idle(); hz.ID_Jump = 1;
        #2;
        chk("jmp_if_id_flush", hz.if_id_flush, 1);
        chk("jmp_pc_stall", hz.pc_stall, 0);
        tick();
        idle(); hz.EX_BranchTaken = 1; hz.EX_MulDivStart = 1;
        #2;
        chk("br_if_id_flush", hz.if_id_flush, 1);
        chk("br_id_ex_flush", hz.id_ex_flush, 1);
        chk("br_pc_stall", hz.pc_stall, 0);
        tick();
        idle();
        #2;
        chk("br_after_md_busy", hz.md_busy, 0);
        chk("br_flush_cnt", hz.flush_cnt, 1);
        chk("br_stall_cnt", hz.stall_cnt, 2);
        // mul/div held high for its whole EX residency
        for (int k = 0; k < L; k++) begin
            tick();
            idle(); hz.EX_MulDivStart = 1;
            #2;
            chk("md_pc_stall", hz.pc_stall, (k < L - 1) ? 1 : 0);
            chk("md_ex_mem_flush", hz.ex_mem_flush, (k < L - 1) ? 1 : 0);
            chk("md_busy_hold", hz.md_busy, 1);
        end
        tick();
        idle();
        #2;
        chk("md_done_busy", hz.md_busy, 0);
        chk("md_stall_cnt", hz.stall_cnt, 5);
        tick();
        hz.MEM_RegWrite = 1; hz.MEM_dst = 5; hz.WB_RegWrite = 1; hz.WB_dst = 5;
        hz.EX_rs = 5; hz.EX_rt = 0;
        #2;
        chk("fwd_a_mem", hz.fwd_a, 2'b01);
        chk("fwd_b_zero", hz.fwd_b, 2'b00);
        hz.MEM_RegWrite = 0;
        #1;
        chk("fwd_a_wb", hz.fwd_a, 2'b10);
        // reset during the second MD_WAIT cycle
        tick();
        idle(); hz.EX_MulDivStart = 1;
        tick();
        tick();
        rst = 1;
        #2;
        chk("mdrst_id_ex_flush", hz.id_ex_flush, 1);
        chk("mdrst_md_busy", hz.md_busy, 0);
        chk("mdrst_pc_stall", hz.pc_stall, 0);
        tick();
        rst = 0; idle();
        #2;
        chk("mdrst_after_busy", hz.md_busy, 0);
        chk("mdrst_stall_cnt", hz.stall_cnt, 0);
        chk("mdrst_flush_cnt", hz.flush_cnt, 0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 79) == 0);
            hz.ID_rs = 5'($urandom_range(0, 3));
            hz.ID_rt = 5'($urandom_range(0, 3));
            hz.ID_UsesRs = 1'($urandom_range(0, 1));
            hz.ID_UsesRt = 1'($urandom_range(0, 1));
            hz.ID_Jump = ($urandom_range(0, 3) == 0);
            hz.EX_rs = 5'($urandom_range(0, 3));
            hz.EX_rt = 5'($urandom_range(0, 3));
            hz.EX_dst = 5'($urandom_range(0, 3));
            hz.EX_MemRead = 1'($urandom_range(0, 1));
            hz.EX_RegWrite = 1'($urandom_range(0, 1));
            hz.EX_BranchTaken = ($urandom_range(0, 7) == 0);
            hz.EX_MulDivStart = ($urandom_range(0, 5) == 0);
            hz.MEM_RegWrite = 1'($urandom_range(0, 1));
            hz.MEM_dst = 5'($urandom_range(0, 3));
            hz.WB_RegWrite = 1'($urandom_range(0, 1));
            hz.WB_dst = 5'($urandom_range(0, 3));
        end
        tick();
        #6;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
